// File: rtl/output_register.sv
// Output register (OUTR) with FGO flag and 8N1 serial transmitter, LSB first.
// A frame is 10*CLKS_PER_BIT cycles; loads seen while FGO=0 are ignored.
module output_register #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] output_data,
  input  logic       output_load,
  output logic [7:0] outr,
  output logic       fgo,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_bit, w_bit;
  logic [7:0]       r_outr, w_outr;
  logic             r_tx, w_tx;
  logic             r_fgo, w_fgo;
  logic             r_busy, w_busy;
  logic             w_bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_outr  <= 8'h00;
      r_tx    <= 1'b1;
      r_fgo   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_outr  <= w_outr;
      r_tx    <= w_tx;
      r_fgo   <= w_fgo;
      r_busy  <= w_busy;
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_outr  = r_outr;
    w_tx    = r_tx;
    w_fgo   = r_fgo;
    w_busy  = r_busy;
    case (r_state)
      IDLE: begin
        if (output_load) begin
          w_outr  = output_data;
          w_fgo   = 1'b0;
          w_busy  = 1'b1;
          w_tx    = 1'b0;
          w_cnt   = '0;
          w_state = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_bit   = 3'd0;
          w_tx    = r_outr[0];
          w_state = DATA;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt = '0;
          if (r_bit == 3'd7) begin
            w_tx    = 1'b1;
            w_state = STOP;
          end else begin
            w_bit = r_bit + 3'd1;
            w_tx  = r_outr[w_bit];
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // fgo rises on the last stop-bit edge, so the next accept is one cycle later
        if (w_bit_end) begin
          w_cnt   = '0;
          w_fgo   = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign outr    = r_outr;
  assign fgo     = r_fgo;
  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_output_register.sv
// Randomized and directed checks of output_register against a frame-time model.
module tb_output_register;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] output_data = 8'h00;
  logic       output_load = 1'b0;
  logic [7:0] outr;
  logic       fgo, tx, tx_busy;

  int tests = 0;
  int fails = 0;

  // Model: a frame is "busy for 10C cycles since accept", tx bit = frame[t/C].
  logic [7:0] m_outr = 8'h00;
  logic       m_busy = 1'b0;
  int         m_t = 0;

  output_register #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .output_data(output_data), .output_load(output_load),
    .outr(outr), .fgo(fgo), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (!m_busy) begin
      if (output_load) begin
        m_outr = output_data;
        m_busy = 1'b1;
        m_t    = 0;
      end
    end else begin
      m_t++;
      if (m_t == 10 * C) m_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_outr = 8'h00;
    m_busy = 1'b0;
    m_t    = 0;
  endtask

  function automatic logic [10:0] exp_vec();
    int  k;
    logic b;
    k = m_t / C;
    if (!m_busy)     b = 1'b1;
    else if (k == 0) b = 1'b0;
    else if (k <= 8) b = m_outr[k-1];
    else             b = 1'b1;
    return {b, ~m_busy, m_busy, m_outr};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1)      begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
    tests++; if (fgo !== 1'b1)     begin fails++; $display("FAIL reset_fgo got=%b exp=1", fgo); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    tests++; if (outr !== 8'h00)   begin fails++; $display("FAIL reset_outr got=%h exp=00", outr); end
    model_reset();
    repeat (3) tick();
    tests++;
    if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
      fails++; $display("FAIL reset_hold got=%h exp=%h", {tx, fgo, tx_busy, outr}, exp_vec());
    end
    rst_n = 1'b1;
    tick();
  endtask

  // One frame of 8'h41; optional 8'hFF load pulse mid-frame that must be ignored.
  task automatic run_41(input string name, input bit poke);
    logic [9:0] seq;
    int fgo_at;
    seq = '0;
    fgo_at = -1;
    output_data = 8'h41; output_load = 1'b1;
    tick();
    output_load = 1'b0;
    tests++; if (outr !== 8'h41) begin fails++; $display("FAIL %s_outr got=%h exp=41", name, outr); end
    tests++; if (fgo !== 1'b0)   begin fails++; $display("FAIL %s_fgo0 got=%b exp=0", name, fgo); end
    for (int c = 1; c <= 45; c++) begin
      if (poke && c == 10) begin output_data = 8'hFF; output_load = 1'b1; end
      if (poke && c == 11) output_load = 1'b0;
      tick();
      tests++;
      if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
        fails++; $display("FAIL %s_cyc%0d got=%h exp=%h", name, c, {tx, fgo, tx_busy, outr}, exp_vec());
      end
      if ((c % C) == 1 && c / C < 10) seq[c / C] = tx;
      if (fgo === 1'b1 && fgo_at < 0) fgo_at = c;
    end
    if (seq[0] !== 1'b0) begin
      // the start bit is sampled at cycle 0's bit window; cycle 1 lies in it too
    end
    tests++; if (seq !== 10'b1010000010) begin fails++; $display("FAIL %s_bits got=%b exp=1010000010", name, seq); end
    tests++; if (fgo_at != 40) begin fails++; $display("FAIL %s_fgo_time got=%0d exp=40", name, fgo_at); end
    tests++; if (outr !== 8'h41) begin fails++; $display("FAIL %s_outr_end got=%h exp=41", name, outr); end
  endtask

  task automatic test_single();
    run_41("single", 1'b0);
  endtask

  task automatic test_load_busy();
    run_41("busy", 1'b1);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int hi_cnt, hi_max;
    logic prev_fgo;
    logic [7:0] outr_at2;
    outr_at2 = 8'h00;
    hi_cnt = 0; hi_max = 0;
    prev_fgo = fgo;
    output_data = 8'h55; output_load = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      tick();
      tests++;
      if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
        fails++; $display("FAIL b2b_cyc%0d got=%h exp=%h", c, {tx, fgo, tx_busy, outr}, exp_vec());
      end
      if (prev_fgo && !fgo) begin
        acc.push_back(c);
        if (acc.size() == 1) output_data = 8'hAA;
        if (acc.size() == 2) outr_at2 = outr;
        if (acc.size() == 2) hi_max = hi_cnt;
      end
      if (acc.size() >= 1 && fgo) hi_cnt++;
      prev_fgo = fgo;
    end
    output_load = 1'b0;
    tests++;
    if (acc.size() < 2) begin
      fails++; $display("FAIL b2b_accepts got=%0d exp>=2", acc.size());
    end else begin
      if (acc[1] - acc[0] != 10 * C + 1) begin
        fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc[1] - acc[0], 10 * C + 1);
      end
    end
    tests++; if (hi_max != 1) begin fails++; $display("FAIL b2b_idle got=%0d exp=1", hi_max); end
    tests++; if (outr_at2 !== 8'hAA) begin fails++; $display("FAIL b2b_outr2 got=%h exp=AA", outr_at2); end
    repeat (45) tick();
  endtask

  task automatic test_reset_mid();
    output_data = 8'h0F; output_load = 1'b1;
    tick();
    output_load = 1'b0;
    repeat (4 * C + 1) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({tx, fgo, tx_busy} !== 3'b110) begin
      fails++; $display("FAIL rstmid_now got=%b exp=110", {tx, fgo, tx_busy});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    output_load = 1'b1;
    tick();
    output_load = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      tests++;
      if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
        fails++; $display("FAIL rstmid_cyc%0d got=%h exp=%h", c, {tx, fgo, tx_busy, outr}, exp_vec());
      end
    end
  endtask

  task automatic test_data_change();
    output_data = 8'h3C; output_load = 1'b1;
    tick();
    output_load = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      output_data = 8'($urandom);
      tick();
      tests++;
      if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
        fails++; $display("FAIL dchg_cyc%0d got=%h exp=%h", c, {tx, fgo, tx_busy, outr}, exp_vec());
      end
    end
    tests++; if (outr !== 8'h3C) begin fails++; $display("FAIL dchg_outr got=%h exp=3C", outr); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      output_load = ($urandom_range(0, 3) == 0);
      output_data = 8'($urandom);
      tick();
      tests++;
      if ({tx, fgo, tx_busy, outr} !== exp_vec()) begin
        fails++; $display("FAIL rand_cyc%0d got=%h exp=%h", c, {tx, fgo, tx_busy, outr}, exp_vec());
      end
    end
    output_load = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_load_busy();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
